// File: rtl/cpu_fetch_pkg.sv
// Shared encodings for the instruction fetch unit: FSM states, next-PC select codes
// and fault codes, plus a small alignment helper.
package cpu_fetch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;
  localparam logic [1:0] PC_J   = 2'b11;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b01;
  localparam logic [1:0] FAULT_MISALIGN = 2'b10;

  function automatic logic word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/cpu_next_pc.sv
// Combinational next-PC selection: sequential, PC-relative branch, register jump
// and region-absolute jump. All adds wrap modulo 2^32.
module cpu_next_pc (
  input  logic [31:0] pc4,
  input  logic [31:0] inst,
  input  logic [31:0] ra,
  input  logic [1:0]  pcsource,
  output logic [31:0] next_pc
);
  import cpu_fetch_pkg::*;

  logic [31:0] br_off_s;
  logic        unused_inst_s;

  assign br_off_s      = {{14{inst[15]}}, inst[15:0], 2'b00};
  assign unused_inst_s = ^inst[31:26];

  // Target mux driven by the control unit's pcsource code
  always_comb begin
    next_pc = pc4;
    case (pcsource)
      PC_SEQ:  next_pc = pc4;
      PC_BR:   next_pc = pc4 + br_off_s;
      PC_JR:   next_pc = ra;
      PC_J:    next_pc = {pc4[31:28], inst[25:0], 2'b00};
      default: next_pc = pc4;
    endcase
  end

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch unit: requests one word at pc, holds it for a one-cycle execute
// strobe, then redirects pc; misaligned targets and fetch timeouts stick in FAULT.
module cpu_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pcsource,
  input  logic [31:0] ra,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        inst_valid,
  output logic        fault,
  output logic [1:0]  fault_code
);
  import cpu_fetch_pkg::*;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [1:0]  state_r;
  logic [31:0] pc_r;
  logic [31:0] inst_r;
  logic [7:0]  wait_cnt_r;
  logic        imem_req_r;
  logic        inst_valid_r;
  logic        fault_r;
  logic [1:0]  fault_code_r;
  logic [31:0] pc4_s;
  logic [31:0] next_pc_s;

  assign pc4_s      = pc_r + 32'd4;
  assign pc         = pc_r;
  assign pc4        = pc4_s;
  assign imem_addr  = pc_r;
  assign imem_req   = imem_req_r;
  assign inst       = inst_r;
  assign inst_valid = inst_valid_r;
  assign fault      = fault_r;
  assign fault_code = fault_code_r;

  cpu_next_pc u_next_pc (
    .pc4      (pc4_s),
    .inst     (inst_r),
    .ra       (ra),
    .pcsource (pcsource),
    .next_pc  (next_pc_s)
  );

  // Fetch FSM; wait_cnt equal to TIMEOUT still lets a same-cycle ack win
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      pc_r         <= RESET_PC;
      inst_r       <= 32'h0000_0000;
      wait_cnt_r   <= 8'd0;
      imem_req_r   <= 1'b0;
      inst_valid_r <= 1'b0;
      fault_r      <= 1'b0;
      fault_code_r <= FAULT_NONE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r    <= ST_FETCH;
          imem_req_r <= 1'b1;
          wait_cnt_r <= 8'd0;
        end
        ST_FETCH: begin
          if (imem_req_r && imem_ack) begin
            inst_r       <= imem_rdata;
            state_r      <= ST_EXEC;
            imem_req_r   <= 1'b0;
            inst_valid_r <= 1'b1;
          end else if (wait_cnt_r == TIMEOUT_C) begin
            state_r      <= ST_FAULT;
            imem_req_r   <= 1'b0;
            fault_r      <= 1'b1;
            fault_code_r <= FAULT_TIMEOUT;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        ST_EXEC: begin
          inst_valid_r <= 1'b0;
          if (!word_aligned(next_pc_s)) begin
            state_r      <= ST_FAULT;
            fault_r      <= 1'b1;
            fault_code_r <= FAULT_MISALIGN;
          end else begin
            pc_r       <= next_pc_s;
            state_r    <= ST_FETCH;
            imem_req_r <= 1'b1;
            wait_cnt_r <= 8'd0;
          end
        end
        ST_FAULT: begin
          state_r      <= ST_FAULT;
          imem_req_r   <= 1'b0;
          inst_valid_r <= 1'b0;
          fault_r      <= 1'b1;
        end
        default: begin
          state_r      <= ST_IDLE;
          imem_req_r   <= 1'b0;
          inst_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Self-checking bench: directed scenarios plus randomized instruction streams, checked
// against a transaction-level model of the PC sequence and fetch/execute timing.
module tb_cpu_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TIMEOUT  = 255;

  logic        clk;
  logic        rst;
  logic [1:0]  pcsource;
  logic [31:0] ra;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        inst_valid;
  logic        fault;
  logic [1:0]  fault_code;

  int          checks_cnt;
  int          errors_cnt;
  logic [31:0] exp_pc;

  cpu_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .pcsource   (pcsource),
    .ra         (ra),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .pc         (pc),
    .pc4        (pc4),
    .inst_valid (inst_valid),
    .fault      (fault),
    .fault_code (fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: where the program goes after executing word at cur_pc
  function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] word,
                                             input logic [1:0] sel, input logic [31:0] rs);
    logic [31:0] seq;
    logic [31:0] idx;
    int          imm;
    seq = cur_pc + 32'd4;
    imm = $signed(word[15:0]);
    idx = word & 32'h03FF_FFFF;
    case (sel)
      2'd0:    return seq;
      2'd1:    return seq + 32'(imm * 4);
      2'd2:    return rs;
      default: return (seq & 32'hF000_0000) | (idx * 32'd4);
    endcase
  endfunction

  task automatic reset_dut();
    rst = 1'b1;
    imem_ack = 1'b0;
    step();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_code", 32'(fault_code), 32'd0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_pc4", pc4, RESET_PC + 32'd4);
    chk("rst_inst", inst, 32'd0);
    rst = 1'b0;
    step();
    chk("idle_to_fetch_req", 32'(imem_req), 32'd1);
    exp_pc = RESET_PC;
  endtask

  // One instruction: lat ack-less request cycles, ack, execute cycle, outcome cycle
  task automatic do_fetch(input logic [31:0] rdata, input logic [1:0] ps, input logic [31:0] ra_v,
                          input int lat, output bit faulted);
    int          bad;
    logic [31:0] nxt;
    bad = 0;
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, exp_pc);
    for (int i = 0; i < lat; i++) begin
      imem_ack   = 1'b0;
      pcsource   = 2'($urandom);
      ra         = $urandom;
      imem_rdata = $urandom;
      step();
      if (imem_req !== 1'b1 || imem_addr !== exp_pc || inst_valid !== 1'b0 || fault !== 1'b0) bad++;
    end
    chk("fetch_stall_hold", 32'(bad), 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    pcsource   = ps;
    ra         = ra_v;
    step();
    imem_ack   = 1'($urandom);
    imem_rdata = $urandom;
    chk("exec_valid", 32'(inst_valid), 32'd1);
    chk("exec_inst", inst, rdata);
    chk("exec_pc", pc, exp_pc);
    chk("exec_pc4", pc4, exp_pc + 32'd4);
    chk("exec_req", 32'(imem_req), 32'd0);
    nxt = model_next(exp_pc, rdata, ps, ra_v);
    step();
    imem_ack = 1'b0;
    chk("post_valid", 32'(inst_valid), 32'd0);
    if (nxt[1:0] != 2'b00) begin
      chk("mis_fault", 32'(fault), 32'd1);
      chk("mis_code", 32'(fault_code), 32'd2);
      chk("mis_pc", pc, exp_pc);
      chk("mis_req", 32'(imem_req), 32'd0);
      faulted = 1'b1;
    end else begin
      chk("next_req", 32'(imem_req), 32'd1);
      chk("next_addr", imem_addr, nxt);
      chk("next_fault", 32'(fault), 32'd0);
      exp_pc  = nxt;
      faulted = 1'b0;
    end
  endtask

  task automatic check_sticky(input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      imem_ack   = 1'($urandom);
      imem_rdata = $urandom;
      pcsource   = 2'($urandom);
      ra         = $urandom;
      step();
      if (fault !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== exp_pc ||
          pc4 !== exp_pc + 32'd4) bad++;
    end
    imem_ack = 1'b0;
    chk("fault_sticky", 32'(bad), 32'd0);
  endtask

  initial begin
    bit          f;
    int          bad;
    logic [31:0] ra_r;
    checks_cnt = 0;
    errors_cnt = 0;
    rst        = 1'b1;
    pcsource   = 2'b00;
    ra         = 32'd0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    exp_pc     = RESET_PC;

    // Reset, sequential fetch, branch back, jr/j/jr, misaligned jr
    reset_dut();
    do_fetch(32'h2008_0005, 2'b00, 32'd0, 0, f);
    do_fetch(32'h2008_0006, 2'b00, 32'd0, 1, f);
    chk("at_pc8", exp_pc, 32'd8);
    do_fetch(32'h1000_FFFE, 2'b01, 32'd0, 2, f);
    chk("branch_back", imem_addr, 32'h0000_0004);
    do_fetch(32'h0000_0008, 2'b10, 32'h1000_0000, 0, f);
    do_fetch(32'h0800_0010, 2'b11, 32'd0, 0, f);
    chk("jump_target", imem_addr, 32'h1000_0040);
    do_fetch(32'h0000_0008, 2'b10, 32'h0000_0100, 0, f);
    chk("jr_target", imem_addr, 32'h0000_0100);
    do_fetch(32'h0000_0008, 2'b10, 32'h0000_0102, 0, f);
    chk("jr_misaligned", 32'(f), 32'd1);
    check_sticky(4);

    // PC wrap from the top of the address space is legal
    reset_dut();
    do_fetch(32'h0000_0008, 2'b10, 32'hFFFF_FFFC, 0, f);
    do_fetch(32'h0000_0000, 2'b00, 32'd0, 0, f);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    chk("wrap_fault", 32'(f), 32'd0);

    // Timeout boundary: ack on the last allowed wait cycle wins, one more cycle faults
    reset_dut();
    do_fetch(32'h0000_0000, 2'b00, 32'd0, TIMEOUT, f);
    bad = 0;
    for (int i = 0; i <= TIMEOUT; i++) begin
      if (imem_req !== 1'b1 || fault !== 1'b0) bad++;
      imem_ack = 1'b0;
      step();
    end
    chk("timeout_req_held", 32'(bad), 32'd0);
    chk("timeout_fault", 32'(fault), 32'd1);
    chk("timeout_code", 32'(fault_code), 32'd1);
    chk("timeout_req_drop", 32'(imem_req), 32'd0);
    check_sticky(3);
    reset_dut();
    chk("restart_addr", imem_addr, RESET_PC);

    // Reset mid-fetch: an ack arriving while IDLE is ignored
    do_fetch(32'h0000_0000, 2'b00, 32'd0, 0, f);
    rst = 1'b1;
    step();
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_pc", pc, RESET_PC);
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    chk("late_ack_inst", inst, 32'd0);
    chk("late_ack_valid", 32'(inst_valid), 32'd0);
    chk("late_ack_refetch", 32'(imem_req), 32'd1);
    exp_pc = RESET_PC;
    do_fetch(32'h1234_5678, 2'b00, 32'd0, 1, f);

    // Randomized instruction streams
    for (int n = 0; n < 60; n++) begin
      ra_r = $urandom;
      if ($urandom_range(0, 7) != 0) ra_r[1:0] = 2'b00;
      do_fetch($urandom, 2'($urandom), ra_r, $urandom_range(0, 5), f);
      if (f) begin
        check_sticky(2);
        reset_dut();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
